// File: rtl/data_sram_responder_if.sv
// ============================================================================
// data_sram_responder_if : CPU data SRAM port bundle (request in, response out)
// Revision 1.0
// ============================================================================
`default_nettype none

interface data_sram_responder_if;
   logic        en;
   logic [3:0]  wen;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        err;

   modport master (output en, wen, addr, wdata, input rdata, err);
   modport slave  (input en, wen, addr, wdata, output rdata, err);
endinterface

`default_nettype wire

// File: rtl/data_sram_responder.sv
// ============================================================================
// data_sram_responder : 1-cycle-latency data SRAM with LED/timer/errcnt MMIO
// Revision 1.0
// ============================================================================
`default_nettype none

module data_sram_responder #(
   parameter int          ADDR_W    = 12,
   parameter logic [31:0] MMIO_BASE = 32'hBFAF_0000
) (
   input  wire logic            clk,
   input  wire logic            resetn,
   data_sram_responder_if.slave bus,
   output logic [15:0]          led,
   output logic [31:0]          timer
);

   localparam int          DEPTH      = 1 << ADDR_W;
   localparam logic [13:0] OFF_LED    = 14'd0;
   localparam logic [13:0] OFF_TIMER  = 14'd1;
   localparam logic [13:0] OFF_ERRCNT = 14'd2;

   logic [31:0] mem [DEPTH];

   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic [15:0] led_q, led_d;
   logic [31:0] timer_q, timer_d;
   logic [31:0] errcnt_q, errcnt_d;

   logic              is_mmio;
   logic              is_ram;
   logic [ADDR_W-1:0] idx;
   logic [31:0]       ram_new;
   logic [15:0]       led_new;
   logic [31:0]       timer_new;
   logic              ram_we;
   logic              unused_addr;

   assign unused_addr = ^bus.addr[1:0];

   function automatic logic [31:0] merge(input logic [31:0] old_w,
                                         input logic [31:0] new_w,
                                         input logic [3:0]  be);
      logic [31:0] res;
      res = old_w;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
      end
      return res;
   endfunction

   always_comb begin
      is_mmio   = (bus.addr[31:16] == MMIO_BASE[31:16]);
      is_ram    = ((bus.addr >> (ADDR_W + 2)) == 32'd0);
      idx       = bus.addr[ADDR_W+1:2];
      ram_new   = merge(mem[idx], bus.wdata, bus.wen);
      led_new   = {bus.wen[1] ? bus.wdata[15:8] : led_q[15:8],
                   bus.wen[0] ? bus.wdata[7:0]  : led_q[7:0]};
      timer_new = merge(timer_q, bus.wdata, bus.wen);

      rdata_d  = rdata_q;
      err_d    = 1'b0;
      led_d    = led_q;
      timer_d  = timer_q + 32'd1;
      errcnt_d = errcnt_q;
      ram_we   = 1'b0;

      if (bus.en) begin
         if (is_mmio) begin
            case (bus.addr[15:2])
               OFF_LED: begin
                  led_d   = led_new;
                  rdata_d = {16'h0000, led_new};
               end
               OFF_TIMER: begin
                  // A load replaces this cycle's increment and is read back write-first.
                  if (|bus.wen) begin
                     timer_d = timer_new;
                     rdata_d = timer_new;
                  end else begin
                     rdata_d = timer_q;
                  end
               end
               OFF_ERRCNT: rdata_d = errcnt_q;
               default:    rdata_d = 32'h0000_0000;
            endcase
         end else if (is_ram) begin
            ram_we  = |bus.wen;
            rdata_d = ram_new;
         end else begin
            rdata_d  = 32'h0000_0000;
            err_d    = 1'b1;
            errcnt_d = errcnt_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         rdata_q  <= 32'h0000_0000;
         err_q    <= 1'b0;
         led_q    <= 16'h0000;
         timer_q  <= 32'h0000_0000;
         errcnt_q <= 32'h0000_0000;
      end else begin
         rdata_q  <= rdata_d;
         err_q    <= err_d;
         led_q    <= led_d;
         timer_q  <= timer_d;
         errcnt_q <= errcnt_d;
      end
   end

   // Storage has no reset; a request in a reset cycle must not write.
   always_ff @(posedge clk) begin
      if (resetn && ram_we) mem[idx] <= ram_new;
   end

   assign bus.rdata = rdata_q;
   assign bus.err   = err_q;
   assign led       = led_q;
   assign timer     = timer_q;

endmodule

`default_nettype wire

// File: tb/tb_data_sram_responder.sv
// ============================================================================
// tb_data_sram_responder : directed plan plus random traffic vs. reference model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_data_sram_responder;

   localparam int AW    = 12;
   localparam int DEPTH = 1 << AW;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic [15:0] led;
   logic [31:0] timer;

   data_sram_responder_if bus();

   data_sram_responder #(.ADDR_W(AW), .MMIO_BASE(32'hBFAF_0000)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus.slave),
      .led    (led),
      .timer  (timer)
   );

   always #5 clk = ~clk;

   // Reference state: RAM contents with per-lane "known" flags (RAM is never reset).
   bit [31:0] m_ram [DEPTH];
   bit [3:0]  m_vld [DEPTH];
   bit [31:0] m_rdata, m_rmask, m_timer, m_errcnt;
   bit [15:0] m_led;
   bit        m_err;
   int        n_tests = 0;
   int        n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit [31:0] lanes(input bit [3:0] w);
      return {{8{w[3]}}, {8{w[2]}}, {8{w[1]}}, {8{w[0]}}};
   endfunction

   task automatic model_edge(input bit rn, input bit e, input bit [3:0] w,
                             input bit [31:0] a, input bit [31:0] d);
      bit [31:0] mask, old_timer;
      int        ix;
      if (!rn) begin
         m_rdata = 0; m_rmask = '1; m_err = 0; m_led = 0; m_timer = 0; m_errcnt = 0;
         return;
      end
      old_timer = m_timer;
      m_timer   = m_timer + 1;
      m_err     = 0;
      if (!e) return;
      mask = lanes(w);
      if (a[31:16] == 16'hBFAF) begin
         m_rmask = '1;
         case (a[15:0] & 16'hFFFC)
            16'h0000: begin
               m_led   = (m_led & ~mask[15:0]) | (d[15:0] & mask[15:0]);
               m_rdata = {16'h0, m_led};
            end
            16'h0004: begin
               if (w != 0) begin
                  m_timer = (old_timer & ~mask) | (d & mask);
                  m_rdata = m_timer;
               end else begin
                  m_rdata = old_timer;
               end
            end
            16'h0008: m_rdata = m_errcnt;
            default:  m_rdata = 0;
         endcase
      end else if (a < 32'h0000_4000) begin
         ix        = int'(a[13:2]);
         m_ram[ix] = (m_ram[ix] & ~mask) | (d & mask);
         m_vld[ix] = m_vld[ix] | w;
         m_rdata   = m_ram[ix];
         m_rmask   = lanes(m_vld[ix]);
      end else begin
         m_rdata  = 0;
         m_rmask  = '1;
         m_err    = 1;
         m_errcnt = m_errcnt + 1;
      end
   endtask

   task automatic cycle(input bit rn, input bit e, input bit [3:0] w,
                        input bit [31:0] a, input bit [31:0] d);
      resetn    = rn;
      bus.en    = e;
      bus.wen   = w;
      bus.addr  = a;
      bus.wdata = d;
      @(posedge clk);
      model_edge(rn, e, w, a, d);
      #1;
      check("rdata", bus.rdata & m_rmask, m_rdata & m_rmask);
      check("err",   {31'h0, bus.err}, {31'h0, m_err});
      check("led",   {16'h0, led}, {16'h0, m_led});
      check("timer", timer, m_timer);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cycle(1, 0, 4'h0, 32'h0, 32'h0);
   endtask

   function automatic bit [31:0] rand_addr();
      int kind;
      kind = $urandom_range(0, 9);
      case (kind)
         0, 1, 2, 3: return {26'h0, 4'($urandom_range(0, 15)), 2'($urandom)};
         4:          return 32'h0000_3FFC | 32'($urandom_range(0, 3));
         5:          return 32'h0000_4000 + 32'($urandom_range(0, 7));
         6:          return 32'($urandom) | 32'h0001_0000;
         default:    return {16'hBFAF, 12'h0, 2'($urandom_range(0, 3)), 2'($urandom)};
      endcase
   endfunction

   initial begin
      bus.en = 0; bus.wen = 0; bus.addr = 0; bus.wdata = 0;
      m_rmask = '1;

      cycle(0, 0, 4'h0, 32'h0, 32'h0);
      cycle(0, 1, 4'hF, 32'h10, 32'h5555_5555);
      check("reset_rdata", bus.rdata, 32'h0);
      check("reset_timer", timer, 32'h0);

      // Timer: 10 idle edges after reset, then read pre-edge value.
      idle(10);
      cycle(1, 1, 4'h0, 32'hBFAF_0004, 32'h0);
      check("timer_read", bus.rdata, 32'd10);
      cycle(1, 1, 4'hF, 32'hBFAF_0004, 32'hFFFF_FFFE);
      check("timer_load", bus.rdata, 32'hFFFF_FFFE);
      idle(2);
      check("timer_wrap", timer, 32'h0);

      // RAM write-first and byte lanes.
      cycle(1, 1, 4'hF, 32'h0, 32'h0BAD_F00D);
      cycle(1, 1, 4'hF, 32'h10, 32'h1122_3344);
      check("wr_first", bus.rdata, 32'h1122_3344);
      cycle(1, 1, 4'h0, 32'h10, 32'h0);
      check("rd_back", bus.rdata, 32'h1122_3344);
      cycle(1, 1, 4'b0101, 32'h10, 32'hAABB_CCDD);
      check("lanes_wr", bus.rdata, 32'h11BB_33DD);
      cycle(1, 1, 4'h0, 32'h10, 32'h0);
      check("lanes_rd", bus.rdata, 32'h11BB_33DD);

      // Out-of-range then counter readback.
      cycle(1, 1, 4'hF, 32'h0001_0000, 32'hFFFF_FFFF);
      check("oor_err", {31'h0, bus.err}, 32'h1);
      cycle(1, 1, 4'h0, 32'hBFAF_0008, 32'h0);
      check("errcnt_1", bus.rdata, 32'h1);
      cycle(1, 1, 4'h0, 32'h0, 32'h0);
      check("word0_kept", bus.rdata, 32'h0BAD_F00D);
      cycle(1, 1, 4'hF, 32'h4000, 32'h1);
      cycle(1, 1, 4'hF, 32'h0000_4004, 32'h1);
      check("oor_b2b", {31'h0, bus.err}, 32'h1);
      cycle(1, 1, 4'hF, 32'hBFAF_0008, 32'h1234);
      check("errcnt_ro", bus.rdata, 32'h3);

      // LED.
      cycle(1, 1, 4'hF, 32'hBFAF_0000, 32'hDEAD_BEEF);
      check("led_wr", {16'h0, led}, 32'h0000_BEEF);
      cycle(1, 1, 4'h0, 32'hBFAF_0000, 32'h0);
      check("led_rd", bus.rdata, 32'h0000_BEEF);
      cycle(1, 1, 4'b1100, 32'hBFAF_0000, 32'h1234_5678);
      check("led_hi_lanes", {16'h0, led}, 32'h0000_BEEF);
      cycle(1, 1, 4'hF, 32'hBFAF_0010, 32'h1234_5678);
      check("mmio_other", bus.rdata, 32'h0);

      // Reset mid-operation must drop the write.
      cycle(1, 1, 4'hF, 32'h20, 32'hCAFE_0020);
      cycle(0, 1, 4'hF, 32'h20, 32'hDEAD_DEAD);
      check("rst_led", {16'h0, led}, 32'h0);
      cycle(1, 1, 4'h0, 32'hBFAF_0008, 32'h0);
      check("rst_errcnt", bus.rdata, 32'h0);
      cycle(1, 1, 4'h0, 32'h20, 32'h0);
      check("rst_keep", bus.rdata, 32'hCAFE_0020);

      // Random traffic against the model.
      for (int i = 0; i < 600; i++) begin
         bit        rn, e;
         bit [3:0]  w;
         rn = ($urandom_range(0, 59) != 0);
         e  = ($urandom_range(0, 3) != 0);
         w  = ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom);
         cycle(rn, e, w, rand_addr(), $urandom);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout t=%0t", $time);
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
